// File: rtl/fixed_pkg.sv
// Shared types, defaults and range helpers for the signed fixed-point math blocks.
package fixed_pkg;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } round_mode_e;

  localparam int unsigned TOTAL_PREC_D = 27;
  localparam int unsigned FRAC_BITS_D  = 22;

  function automatic logic signed [63:0] fixed_max(input int unsigned width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] fixed_min(input int unsigned width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// Rounds a full-width signed product back to TOTAL_PREC bits and flags overflow.
// FIXED_MULT_SATURATE_EN selects saturation on overflow; otherwise the result wraps.
module fixed_round_sat
  import fixed_pkg::*;
#(
  parameter int TOTAL_PREC = TOTAL_PREC_D,
  parameter int FRAC_BITS  = FRAC_BITS_D
) (
  input  logic signed [2*TOTAL_PREC-1:0] prod_i,
  input  round_mode_e                    mode_i,
  output logic signed [TOTAL_PREC-1:0]   res_o,
  output logic                           ovf_o
);

  localparam int QW = 2*TOTAL_PREC + 1;
  localparam logic signed [QW-1:0] HALF =
    (FRAC_BITS == 0) ? '0 : (QW'(1) <<< (FRAC_BITS - 1));

`ifdef FIXED_MULT_SATURATE_EN
  localparam logic signed [63:0] MAX_W = fixed_max(TOTAL_PREC);
  localparam logic signed [63:0] MIN_W = fixed_min(TOTAL_PREC);
`endif

  logic signed [QW-1:0]          sum;
  logic signed [QW-1:0]          q;
  logic        [QW-TOTAL_PREC:0] hi;

  always_comb begin
    sum = {prod_i[2*TOTAL_PREC-1], prod_i} + ((mode_i == RND_HALF_UP) ? HALF : '0);
    q   = sum >>> FRAC_BITS;
    // In range exactly when every bit from the result sign upward agrees.
    hi    = q[QW-1:TOTAL_PREC-1];
    ovf_o = !((&hi) || !(|hi));
`ifdef FIXED_MULT_SATURATE_EN
    if (ovf_o) res_o = q[QW-1] ? MIN_W[TOTAL_PREC-1:0] : MAX_W[TOTAL_PREC-1:0];
    else       res_o = q[TOTAL_PREC-1:0];
`else
    res_o = q[TOTAL_PREC-1:0];
`endif
  end

endmodule

// File: rtl/fixed_mult_pipe.sv
// Pipelined signed fixed-point multiplier with bubble-collapsing valid/ready stages.
// Overflow handling follows FIXED_MULT_SATURATE_EN (saturate) or wraps when undefined.
module fixed_mult_pipe
  import fixed_pkg::*;
#(
  parameter int TOTAL_PREC = TOTAL_PREC_D,
  parameter int FRAC_BITS  = FRAC_BITS_D,
  parameter int STAGES     = 3,
  parameter int TAG_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [TOTAL_PREC-1:0] a,
  input  logic signed [TOTAL_PREC-1:0] b,
  input  logic                         round_mode,
  input  logic        [TAG_W-1:0]      in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [TOTAL_PREC-1:0] res,
  output logic                         ovf,
  output logic        [TAG_W-1:0]      out_tag
);

  localparam int          PW   = 2*TOTAL_PREC;
  localparam int unsigned LAST = STAGES - 1;

  logic [STAGES-1:0] vld_q, vld_d, ld;

  logic signed [PW-1:0] a_x, b_x, prod_c;
  logic signed [PW-1:0] rs_prod;
  round_mode_e          rs_mode;
  logic [TAG_W-1:0]     rs_tag;
  logic                 rs_vld;

  logic signed [TOTAL_PREC-1:0] rs_res, res_q;
  logic                         rs_ovf, ovf_q;
  logic [TAG_W-1:0]             tag_q;

  assign a_x    = {{TOTAL_PREC{a[TOTAL_PREC-1]}}, a};
  assign b_x    = {{TOTAL_PREC{b[TOTAL_PREC-1]}}, b};
  assign prod_c = a_x * b_x;

  // A stage loads when empty or when its occupant leaves this cycle,
  // which reduces to "empty or the next stage loads".
  always_comb begin
    ld       = '0;
    ld[LAST] = !vld_q[LAST] || out_ready;
    for (int unsigned k = LAST; k > 0; k--) ld[k-1] = !vld_q[k-1] || ld[k];
    vld_d = vld_q;
    if (ld[0]) vld_d[0] = in_valid;
    for (int unsigned k = 1; k < STAGES; k++) if (ld[k]) vld_d[k] = vld_q[k-1];
  end

  assign in_ready = ld[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_d;
  end

  if (STAGES == 1) begin : g_single
    assign rs_prod = prod_c;
    assign rs_mode = round_mode_e'(round_mode);
    assign rs_tag  = in_tag;
    assign rs_vld  = in_valid;
  end else begin : g_multi
    logic signed [PW-1:0] prod_q [STAGES-1];
    round_mode_e          mode_q [STAGES-1];
    logic [TAG_W-1:0]     ptag_q [STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned k = 0; k < STAGES-1; k++) begin
          prod_q[k] <= '0;
          mode_q[k] <= RND_TRUNC;
          ptag_q[k] <= '0;
        end
      end else begin
        if (ld[0] && in_valid) begin
          prod_q[0] <= prod_c;
          mode_q[0] <= round_mode_e'(round_mode);
          ptag_q[0] <= in_tag;
        end
        for (int unsigned k = 1; k < STAGES-1; k++) begin
          if (ld[k] && vld_q[k-1]) begin
            prod_q[k] <= prod_q[k-1];
            mode_q[k] <= mode_q[k-1];
            ptag_q[k] <= ptag_q[k-1];
          end
        end
      end
    end

    assign rs_prod = prod_q[STAGES-2];
    assign rs_mode = mode_q[STAGES-2];
    assign rs_tag  = ptag_q[STAGES-2];
    assign rs_vld  = vld_q[STAGES-2];
  end

  fixed_round_sat #(
    .TOTAL_PREC (TOTAL_PREC),
    .FRAC_BITS  (FRAC_BITS)
  ) u_round_sat (
    .prod_i (rs_prod),
    .mode_i (rs_mode),
    .res_o  (rs_res),
    .ovf_o  (rs_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      ovf_q <= 1'b0;
      tag_q <= '0;
    end else if (ld[LAST] && rs_vld) begin
      res_q <= rs_res;
      ovf_q <= rs_ovf;
      tag_q <= rs_tag;
    end
  end

  assign out_valid = vld_q[LAST];
  assign res       = res_q;
  assign ovf       = ovf_q;
  assign out_tag   = tag_q;

endmodule
